counter_mod_k_down_ro: RTL
==========================

# counter_mod_k_down_ro

Loadable modulo-k down-counter with roll-under flag: counts k-1, k-2, …, 0 and then wraps back to k-1, or stops at 0 in one-shot mode. It is the count-down counterpart of the modulo-k up-counter with roll-over output. It serves as a reloadable interval timer: the datapath loads a period, and downstream logic consumes the roll-under flag as a period tick or a timeout.

## Interface
- `N`, default 3: width of the modulus input and the count register.
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_reset_n`, input, 1: asynchronous, active-low reset.
- `i_k`, input, N: modulus. Sampled only on a load.
- `i_load`, input, 1: synchronous load/restart request.
- `i_en`, input, 1: count enable.
- `i_one_shot`, input, 1: mode select, sampled on a load. 0 = periodic, 1 = one-shot.
- `o_count`, output, N: current count value.
- `o_roll_under`, output, 1: high while in RUN with count == 0.
- `o_busy`, output, 1: high while in RUN.
- `o_done`, output, 1: high while in DONE (one-shot expired).

## Operation
- Internal registers:
  - `k_q` (N bits): latched modulus.
  - `mode_q`: latched mode.
  - `count_q` (N bits).
  - `state`: one of IDLE, RUN, DONE.
- All outputs are decoded from registered state only. There are no combinational paths from inputs to outputs.
- Reset (`i_reset_n` = 0), applied asynchronously:
  - state = IDLE, `count_q` = 0, `k_q` = 0, `mode_q` = 0.
  - `o_count` = 0, `o_roll_under` = 0, `o_busy` = 0, `o_done` = 0.
- Load (`i_load` = 1 at an edge) acts in any state and has priority over `i_en`:
  - If `i_k` != 0: `k_q` ← `i_k`, `mode_q` ← `i_one_shot`, `count_q` ← `i_k` - 1, state ← RUN.
  - If `i_k` == 0: `k_q` ← 0, `count_q` ← 0, state ← IDLE. No pulses are generated.
- RUN with `i_en` = 1 and no load:
  - `count_q` != 0: `count_q` ← `count_q` - 1.
  - `count_q` == 0, `mode_q` = 0: `count_q` ← `k_q` - 1, stay in RUN (wrap-around).
  - `count_q` == 0, `mode_q` = 1: `count_q` stays 0, state ← DONE.
- RUN with `i_en` = 0: hold all state. `o_roll_under` stays high if the count is held at 0.
- IDLE and DONE: hold all state. Only a load leaves these states.
- State transitions:
  - IDLE → RUN: load with k != 0.
  - RUN → RUN: load with k != 0, or periodic wrap.
  - RUN → DONE: one-shot expiry.
  - DONE → RUN: load with k != 0.
  - Any state → IDLE: load with k == 0, or reset.
- Arithmetic:
  - All arithmetic is modulo 2^N, unsigned.
  - `k_q` - 1 is never evaluated with `k_q` == 0, because the k == 0 load is blocked.
  - k = 2^N - 1 is the largest modulus; the count starts at 2^N - 2.
- k = 1:
  - Periodic: the count stays 0 and `o_roll_under` stays high for every RUN cycle.
  - One-shot: one RUN cycle with the flag high, then DONE at the first enabled edge.
- `i_k` and `i_one_shot` changing during RUN have no effect until the next load.

## Timing
- Load latency is one edge: the cycle after the load edge shows `o_count` = k-1 and `o_busy` = 1.
- Periodic mode, `i_en` held high: `o_roll_under` is high for exactly 1 of every k cycles, namely the cycle in which the count is 0.
- For k = 4 the count sequence after the load edge is 3, 2, 1, 0*, 3, 2, 1, 0*, … (* marks roll-under high).
- One-shot mode, `i_en` high: `o_done` rises k edges after the load edge. It coincides with `o_roll_under` falling.
- Load asserted in the same cycle as a roll-under (count 0): the load wins. The next count is the new `i_k` - 1, not `k_q` - 1.
- Reset asserted mid-count: outputs clear immediately, without waiting for an edge. After deassertion the counter stays in IDLE until a load.

## Test plan
- Reset, then load `i_k` = 4 in periodic mode with `i_en` = 1 for 20 cycles: `o_count` follows 3,2,1,0 repeating, `o_roll_under` is high on every 4th cycle, `o_busy` = 1 throughout.
- Load `i_k` = 3 in one-shot mode with `i_en` = 1: count 2,1,0 with roll-under high in the third cycle, then `o_done` = 1, `o_busy` = 0, and `o_count` holds 0 for 5 or more further cycles.
- Load `i_k` = 5, toggle `i_en` 1,0,0,1,1: count 4,3,3,3,2,1, and `o_roll_under` never goes high early.
- Load `i_k` = 4, run to count 0, then assert load with `i_k` = 2 in that cycle: next counts are 1,0,1,0 rather than 3. Load with `i_k` = 0: state goes to IDLE, count 0, all flags 0.
- Edge moduli: `i_k` = 1 periodic gives `o_roll_under` constantly 1 and count 0. `i_k` = 7 (N = 3) gives the sequence 6..0, a 7-cycle period.
- Pull `i_reset_n` low at count 2, mid-period, not on a clock edge: all outputs are 0 immediately. After release the block stays in IDLE with `i_en` = 1 until the next load.

Source files
------------

// File: rtl/counter_mod_k_down_ro_if.sv
// Control and status bundle for the loadable modulo-k down-counter.
// The slave side belongs to the counter and the master side to the datapath that drives it.
interface counter_mod_k_down_ro_if #(
  parameter int N = 3
);
  logic [N-1:0] i_k;
  logic         i_load;
  logic         i_en;
  logic         i_one_shot;
  logic [N-1:0] o_count;
  logic         o_roll_under;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_k, i_load, i_en, i_one_shot,
    input  o_count, o_roll_under, o_busy, o_done
  );

  modport slave (
    input  i_k, i_load, i_en, i_one_shot,
    output o_count, o_roll_under, o_busy, o_done
  );
endinterface

// File: rtl/counter_mod_k_down_ro.sv
// Reloadable modulo-k down-counter / interval timer with a roll-under flag.
// Counts k-1 down to 0, then wraps (periodic) or parks in DONE (one-shot).
module counter_mod_k_down_ro #(
  parameter int N = 3
) (
  input logic                    i_clk,
  input logic                    i_reset_n,
  counter_mod_k_down_ro_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N-1:0] ONE = N'(1);

  logic [1:0]   state;
  logic [N-1:0] k_q;
  logic [N-1:0] count_q;
  logic         mode_q;

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values together; blocking assignments would create ordering races.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      k_q     <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else if (bus.i_load) begin
      // A zero modulus parks the counter, so k_q - 1 never sees k_q == 0.
      if (bus.i_k != '0) begin
        k_q     <= bus.i_k;
        mode_q  <= bus.i_one_shot;
        count_q <= bus.i_k - ONE;
        state   <= ST_RUN;
      end else begin
        k_q     <= '0;
        count_q <= '0;
        state   <= ST_IDLE;
      end
    end else if (state == ST_RUN && bus.i_en) begin
      if (count_q != '0) begin
        count_q <= count_q - ONE;
      end else if (!mode_q) begin
        count_q <= k_q - ONE;
      end else begin
        state <= ST_DONE;
      end
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign bus.o_count      = count_q;
  assign bus.o_busy       = (state == ST_RUN);
  assign bus.o_done       = (state == ST_DONE);
  assign bus.o_roll_under = (state == ST_RUN) && (count_q == '0);

endmodule
